pic_command_decoder: RTL
========================

Name: pic_command_decoder

Overview:
- Sits directly downstream of the 8259 read/write logic.
- Consumes its chip-select-qualified active-high RD/WR strobes, A0 and the 8-bit data bus.
- Sequences the ICW1–ICW4 initialization words and decodes OCW1–OCW3 in ready mode.
- Drives the registered configuration (vector base, IMR, mode bits, read select, OCW2 commands) to the IRR/ISR/priority logic.

Parameters:
- DATA_W, 8, data bus width; only 8 is supported.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- RD  in  1  qualified read strobe, active high
- WR  in  1  qualified write strobe, active high
- A0  in  1  qualified address bit
- D  in  8  data bus (write data)
- init_done  out  1  ICW sequence complete, ready mode
- vector_base  out  5  T7..T3 from ICW2
- ltim  out  1  level-triggered mode (ICW1 D3)
- single_mode  out  1  SNGL (ICW1 D1)
- cascade_cfg  out  8  ICW3 value
- aeoi  out  1  auto-EOI (ICW4 D1)
- upm  out  1  8086 mode (ICW4 D0)
- imr  out  8  interrupt mask register (OCW1)
- read_isr  out  1  read select: 0 = IRR, 1 = ISR
- ocw2_valid  out  1  one-cycle pulse, OCW2 accepted
- ocw2_cmd  out  3  OCW2 D7..D5 (R, SL, EOI)
- ocw2_level  out  3  OCW2 D2..D0
- special_mask  out  1  special mask mode

Behaviour:
Write capture:
- Each cycle with WR=1, the block registers D and A0 into hold registers.
- If RD=1 in any cycle of a WR-high pulse, that pulse is marked invalid.
- Commit happens at the clk edge where WR_q=1 and WR=0 (trailing edge), using the held values. Outputs update at that same edge, so latency is 1 clk after WR deasserts.
- An invalid pulse commits nothing. The invalid flag clears when WR is low.

Reset values:
- state=IDLE, init_done=0, vector_base=0, ltim=0, single_mode=0, cascade_cfg=0, aeoi=0, upm=0.
- imr=8'hFF, read_isr=0, ocw2_valid=0, ocw2_cmd=0, ocw2_level=0, special_mask=0.
- Reset mid-pulse discards the hold registers and the WR_q history.

ICW1 (A0=0, D4=1) is accepted in any state:
- Latch ic4=D0, single_mode=D1, ltim=D3.
- Clear imr=0, aeoi=0, upm=0, read_isr=0, special_mask=0, init_done=0.
- Go to W_ICW2.

State machine (states IDLE, W_ICW2, W_ICW3, W_ICW4, READY):
- IDLE: only ICW1 is acted on; all other writes are ignored.
- W_ICW2: a write with A0=1 sets vector_base=D[7:3].
  - Next state: W_ICW3 if single_mode=0; else W_ICW4 if ic4=1; else READY.
  - A write with A0=0 that is not ICW1 is ignored.
- W_ICW3: a write with A0=1 sets cascade_cfg=D. Next state: W_ICW4 if ic4=1, else READY.
- W_ICW4: a write with A0=1 sets upm=D0, aeoi=D1. Next state: READY.
- Entering READY sets init_done=1 at the same edge.
- READY:
  - A0=1: OCW1, imr=D.
  - A0=0 with D[4:3]=00: OCW2. ocw2_valid=1 for exactly one clk; ocw2_cmd=D[7:5], ocw2_level=D[2:0] held until the next OCW2.
  - A0=0 with D[4:3]=01: OCW3. If D1=1, read_isr=D0; if D1=0, read_isr is unchanged.
  - A0=0 with D4=1: ICW1 (restart).

Other rules:
- ocw2_valid is 0 in every cycle without an OCW2 commit.
- Back-to-back write pulses separated by one low cycle are each committed.

Optional Feature:
- Macro: PIC_SPECIAL_MASK_EN.
- Defined: an OCW3 with D6=1 (ESMM) sets special_mask=D5 (SMM). An OCW3 with D6=0 leaves it unchanged. ICW1 and reset clear it.
- Undefined: D6/D5 are ignored and special_mask is tied to 0. The port is always present.

Test Plan:
- Reset, then ICW1=8'h13, ICW2=8'h48, ICW4=8'h03 → after the last trailing edge +1 clk: init_done=1, vector_base=5'h09, single_mode=1, aeoi=1, upm=1, imr=8'h00.
- ICW1=8'h11, ICW2=8'h20, ICW3=8'h04, ICW4=8'h01 → cascade_cfg=8'h04, vector_base=5'h04, init_done=1 only after ICW4.
- In READY: OCW1 (A0=1) 8'hA5 → imr=8'hA5. OCW2 8'h20 → ocw2_valid high for 1 clk with ocw2_cmd=3'b001. OCW3 8'h0B → read_isr=1. OCW3 8'h08 → read_isr stays 1.
- WR and RD high together for 3 clks with A0=1, D=8'h00 in READY → imr unchanged, no ocw2_valid.
- ICW1 issued mid-sequence (in W_ICW3) → state returns to W_ICW2, init_done=0, imr=8'h00. A reset asserted while WR is high → no commit on the following WR fall.
- With PIC_SPECIAL_MASK_EN: OCW3 8'h68 → special_mask=1; 8'h48 → 0; 8'h28 → unchanged. Without the macro: special_mask stays 0 for all three.

Source files
------------

// File: rtl/pic_command_decoder.sv
// rtl/pic_command_decoder.sv - 8259 ICW/OCW command decoder; optional special mask via PIC_SPECIAL_MASK_EN
module pic_command_decoder #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RD,
    input  logic              WR,
    input  logic              A0,
    input  logic [DATA_W-1:0] D,
    output logic              init_done,
    output logic [4:0]        vector_base,
    output logic              ltim,
    output logic              single_mode,
    output logic [7:0]        cascade_cfg,
    output logic              aeoi,
    output logic              upm,
    output logic [7:0]        imr,
    output logic              read_isr,
    output logic              ocw2_valid,
    output logic [2:0]        ocw2_cmd,
    output logic [2:0]        ocw2_level,
    output logic              special_mask
);

    typedef enum logic [2:0] {IDLE, W_ICW2, W_ICW3, W_ICW4, READY} state_t;

    state_t            state, state_next;
    logic              wr_q, inv_q, a0_h, ic4;
    logic [DATA_W-1:0] d_h;
    logic              commit;
    logic              is_icw1, do_icw2, do_icw3, do_icw4, do_ocw1, do_ocw2, do_ocw3;

    // A write takes effect on its trailing edge, unless RD overlapped it.
    assign commit = wr_q & ~WR & ~inv_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= 1'b0;
            inv_q <= 1'b0;
            a0_h  <= 1'b0;
            d_h   <= '0;
        end else begin
            wr_q <= WR;
            if (WR) begin
                d_h  <= D;
                a0_h <= A0;
                if (RD)
                    inv_q <= 1'b1;
            end else begin
                inv_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        is_icw1    = 1'b0;
        do_icw2    = 1'b0;
        do_icw3    = 1'b0;
        do_icw4    = 1'b0;
        do_ocw1    = 1'b0;
        do_ocw2    = 1'b0;
        do_ocw3    = 1'b0;
        if (commit) begin
            if (!a0_h && d_h[4]) begin
                is_icw1    = 1'b1;
                state_next = W_ICW2;
            end else begin
                case (state)
                    W_ICW2: if (a0_h) begin
                        do_icw2    = 1'b1;
                        state_next = !single_mode ? W_ICW3 : (ic4 ? W_ICW4 : READY);
                    end
                    W_ICW3: if (a0_h) begin
                        do_icw3    = 1'b1;
                        state_next = ic4 ? W_ICW4 : READY;
                    end
                    W_ICW4: if (a0_h) begin
                        do_icw4    = 1'b1;
                        state_next = READY;
                    end
                    READY: begin
                        if (a0_h)
                            do_ocw1 = 1'b1;
                        else if (!d_h[3])
                            do_ocw2 = 1'b1;
                        else
                            do_ocw3 = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_done    <= 1'b0;
            vector_base  <= 5'd0;
            ltim         <= 1'b0;
            single_mode  <= 1'b0;
            ic4          <= 1'b0;
            cascade_cfg  <= 8'd0;
            aeoi         <= 1'b0;
            upm          <= 1'b0;
            imr          <= 8'hFF;
            read_isr     <= 1'b0;
            ocw2_valid   <= 1'b0;
            ocw2_cmd     <= 3'd0;
            ocw2_level   <= 3'd0;
            special_mask <= 1'b0;
        end else begin
            init_done  <= (state_next == READY);
            ocw2_valid <= do_ocw2;
            if (is_icw1) begin
                ic4          <= d_h[0];
                single_mode  <= d_h[1];
                ltim         <= d_h[3];
                imr          <= 8'h00;
                aeoi         <= 1'b0;
                upm          <= 1'b0;
                read_isr     <= 1'b0;
                special_mask <= 1'b0;
            end
            if (do_icw2)
                vector_base <= d_h[7:3];
            if (do_icw3)
                cascade_cfg <= d_h[7:0];
            if (do_icw4) begin
                upm  <= d_h[0];
                aeoi <= d_h[1];
            end
            if (do_ocw1)
                imr <= d_h[7:0];
            if (do_ocw2) begin
                ocw2_cmd   <= d_h[7:5];
                ocw2_level <= d_h[2:0];
            end
            if (do_ocw3) begin
                if (d_h[1])
                    read_isr <= d_h[0];
`ifdef PIC_SPECIAL_MASK_EN
                if (d_h[6])
                    special_mask <= d_h[5];
`endif
            end
        end
    end

endmodule
